sar_result_avg: RTL and testbench

SAR_RESULT_AVG -- requirements
Module: sar_result_avg

---
 rtl/sar_result_avg.sv | 164 ++++++++++++++++
 tb/tb_sar_result_avg.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_result_avg.sv
// sar_result_avg: accumulates N = 2**AVG_LOG2 SAR conversion results and
// presents their truncated mean on a registered valid/ready output.
// While a result is held and not yet accepted, any further conversion is
// dropped and recorded in a sticky overrun flag.
module sar_result_avg #(
  parameter int WIDTH    = 6,
  parameter int AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                eoc_i,
  input  logic [WIDTH-1:0]    result_i,
  input  logic                clr_i,
  input  logic                out_ready_i,
  output logic [WIDTH-1:0]    avg_o,
  output logic                avg_valid_o,
  output logic                overrun_o,
  output logic [AVG_LOG2-1:0] sample_cnt_o,
  output logic                busy_o
);

  // The accumulator carries AVG_LOG2 guard bits so N full-scale samples fit.
  localparam int ACC_W = WIDTH + AVG_LOG2;

  localparam logic [AVG_LOG2-1:0] CNT_ZERO = AVG_LOG2'(0);
  localparam logic [AVG_LOG2-1:0] CNT_ONE  = AVG_LOG2'(1);
  // Count value at which the next accepted sample is the last of the window.
  localparam logic [AVG_LOG2-1:0] CNT_LAST = AVG_LOG2'((1 << AVG_LOG2) - 1);
  localparam logic [ACC_W-1:0]    ACC_ZERO = ACC_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [AVG_LOG2-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]      avg_q, avg_d;
  logic                  avg_valid_q, avg_valid_d;
  logic                  overrun_q, overrun_d;

  logic [ACC_W-1:0]      result_ext_s;
  logic [ACC_W-1:0]      sum_s;
  logic                  overrun_set_s;

  assign result_ext_s = ACC_W'(result_i);
  assign sum_s        = acc_q + result_ext_s;

  // Next-state, datapath and flag computation for the averaging window.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    avg_d         = avg_q;
    avg_valid_d   = avg_valid_q;
    overrun_set_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A conversion while disabled is simply ignored.
        if (en && eoc_i) begin
          acc_d   = result_ext_s;
          cnt_d   = CNT_ONE;
          state_d = ST_ACCUM;
        end else begin
          acc_d   = ACC_ZERO;
          cnt_d   = CNT_ZERO;
        end
      end

      ST_ACCUM: begin
        if (!en) begin
          // Abort: the partial sum and any coincident sample are lost.
          acc_d   = ACC_ZERO;
          cnt_d   = CNT_ZERO;
          state_d = ST_IDLE;
        end else if (eoc_i) begin
          if (cnt_q != CNT_LAST) begin
            acc_d = sum_s;
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            // Window complete: truncating divide by N is a plain shift.
            avg_d       = WIDTH'(sum_s >> AVG_LOG2);
            avg_valid_d = 1'b1;
            acc_d       = ACC_ZERO;
            cnt_d       = CNT_ZERO;
            state_d     = ST_HOLD;
          end
        end else begin
          acc_d = acc_q;
          cnt_d = cnt_q;
        end
      end

      ST_HOLD: begin
        // avg_valid_q is always set here, so out_ready_i alone completes
        // the handshake. en is deliberately not looked at until then.
        if (out_ready_i) begin
          avg_valid_d = 1'b0;
          if (eoc_i && en) begin
            acc_d   = result_ext_s;
            cnt_d   = CNT_ONE;
            state_d = ST_ACCUM;
          end else begin
            acc_d   = ACC_ZERO;
            cnt_d   = CNT_ZERO;
            state_d = ST_IDLE;
          end
        end else begin
          if (eoc_i) begin
            overrun_set_s = 1'b1;
          end else begin
            overrun_set_s = 1'b0;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        acc_d       = ACC_ZERO;
        cnt_d       = CNT_ZERO;
        avg_valid_d = 1'b0;
      end
    endcase

    // A fresh overrun wins over a clear arriving in the same cycle.
    if (overrun_set_s) begin
      overrun_d = 1'b1;
    end else if (clr_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State and datapath registers with asynchronous reset to an empty window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= ACC_ZERO;
      cnt_q       <= CNT_ZERO;
      avg_q       <= {WIDTH{1'b0}};
      avg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign avg_o        = avg_q;
  assign avg_valid_o  = avg_valid_q;
  assign overrun_o    = overrun_q;
  assign sample_cnt_o = cnt_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sar_result_avg.sv
// Testbench for sar_result_avg: directed vector table, hand-written reset
// sequence, then randomized traffic checked against a window-list model.
module tb_sar_result_avg;

  localparam int W = 6;
  localparam int L = 2;
  localparam int N = 1 << L;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         eoc_i;
  logic [W-1:0] result_i;
  logic         clr_i;
  logic         out_ready_i;
  logic [W-1:0] avg_o;
  logic         avg_valid_o;
  logic         overrun_o;
  logic [L-1:0] sample_cnt_o;
  logic         busy_o;

  int vectors;
  int miscompares;

  sar_result_avg #(.WIDTH(W), .AVG_LOG2(L)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .eoc_i        (eoc_i),
    .result_i     (result_i),
    .clr_i        (clr_i),
    .out_ready_i  (out_ready_i),
    .avg_o        (avg_o),
    .avg_valid_o  (avg_valid_o),
    .overrun_o    (overrun_o),
    .sample_cnt_o (sample_cnt_o),
    .busy_o       (busy_o)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic         eoc;
    logic [W-1:0] res;
    logic         clr;
    logic         rdy;
    logic [W-1:0] e_avg;
    logic         e_val;
    logic         e_ovr;
    logic [L-1:0] e_cnt;
    logic         e_busy;
  } vec_t;

  vec_t tbl[38];

  function automatic vec_t mk(input logic e, input logic v, input int r,
                              input logic c, input logic rd, input int ea,
                              input logic ev, input logic eo, input int ec,
                              input logic eb);
    vec_t t;
    t.en = e; t.eoc = v; t.res = W'(r); t.clr = c; t.rdy = rd;
    t.e_avg = W'(ea); t.e_val = ev; t.e_ovr = eo; t.e_cnt = L'(ec); t.e_busy = eb;
    return t;
  endfunction

  // Reference model: samples of the open window, plus the held result.
  int win[$];
  bit m_hold;
  bit m_valid;
  bit m_ovr;
  int m_avg;

  task automatic model_reset();
    win.delete();
    m_hold  = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_avg   = 0;
  endtask

  task automatic model_step(input logic e, input logic v, input int r,
                            input logic c, input logic rd);
    bit set_ovr;
    int sum;
    set_ovr = 1'b0;
    if (m_hold) begin
      if (rd) begin
        m_hold  = 1'b0;
        m_valid = 1'b0;
        win.delete();
        if (v && e) win.push_back(r);
      end else if (v) begin
        set_ovr = 1'b1;
      end
    end else if (win.size() == 0) begin
      if (e && v) win.push_back(r);
    end else if (!e) begin
      win.delete();
    end else if (v) begin
      win.push_back(r);
      if (win.size() == N) begin
        sum = 0;
        foreach (win[i]) sum += win[i];
        m_avg   = sum / N;
        m_hold  = 1'b1;
        m_valid = 1'b1;
        win.delete();
      end
    end
    if (set_ovr) m_ovr = 1'b1;
    else if (c) m_ovr = 1'b0;
  endtask

  task automatic check(input string nm, input logic [W-1:0] ea, input logic ev,
                       input logic eo, input logic [L-1:0] ec, input logic eb,
                       input logic chk_avg);
    vectors++;
    if ((ev || chk_avg) && avg_o !== ea) begin
      miscompares++;
      $display("FAIL %s: avg_o=%0d expected %0d", nm, avg_o, ea);
    end
    if (avg_valid_o !== ev) begin
      miscompares++;
      $display("FAIL %s: avg_valid_o=%0b expected %0b", nm, avg_valid_o, ev);
    end
    if (overrun_o !== eo) begin
      miscompares++;
      $display("FAIL %s: overrun_o=%0b expected %0b", nm, overrun_o, eo);
    end
    if (sample_cnt_o !== ec) begin
      miscompares++;
      $display("FAIL %s: sample_cnt_o=%0d expected %0d", nm, sample_cnt_o, ec);
    end
    if (busy_o !== eb) begin
      miscompares++;
      $display("FAIL %s: busy_o=%0b expected %0b", nm, busy_o, eb);
    end
  endtask

  task automatic drive(input logic e, input logic v, input int r,
                       input logic c, input logic rd);
    en = e; eoc_i = v; result_i = W'(r); clr_i = c; out_ready_i = rd;
  endtask

  // One clock: drive inputs, let the edge pass, sample 1 ns later.
  task automatic step(input logic e, input logic v, input int r,
                      input logic c, input logic rd);
    drive(e, v, r, c, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_run(input int cycles);
    logic e, v, c, rd;
    int r;
    string nm;
    for (int i = 0; i < cycles; i++) begin
      e  = ($urandom_range(0, 9) != 0);
      v  = $urandom_range(0, 1) != 0;
      c  = ($urandom_range(0, 9) == 0);
      rd = $urandom_range(0, 2) != 0;
      r  = $urandom_range(0, (1 << W) - 1);
      drive(e, v, r, c, rd);
      if ($urandom_range(0, 149) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rand_async_rst", W'(0), 1'b0, 1'b0, L'(0), 1'b0, 1'b1);
        rst_n = 1'b1;
      end
      model_step(e, v, r, c, rd);
      @(posedge clk);
      #1;
      nm = $sformatf("rand[%0d]", i);
      check(nm, W'(m_avg), m_valid, m_ovr, L'(win.size()),
            m_hold || (win.size() != 0), 1'b0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();

    // Directed table: each row is one clock, expected outputs after it.
    tbl[0]  = mk(1, 1, 10, 0, 1,  0, 0, 0, 1, 1);
    tbl[1]  = mk(1, 1, 20, 0, 1,  0, 0, 0, 2, 1);
    tbl[2]  = mk(1, 1, 30, 0, 1,  0, 0, 0, 3, 1);
    tbl[3]  = mk(1, 1, 41, 0, 1, 25, 1, 0, 0, 1);
    tbl[4]  = mk(1, 0,  0, 0, 1,  0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 63, 0, 1,  0, 0, 0, 1, 1);
    tbl[6]  = mk(1, 1, 63, 0, 1,  0, 0, 0, 2, 1);
    tbl[7]  = mk(1, 1, 63, 0, 1,  0, 0, 0, 3, 1);
    tbl[8]  = mk(1, 1, 63, 0, 1, 63, 1, 0, 0, 1);
    tbl[9]  = mk(1, 0,  0, 0, 1,  0, 0, 0, 0, 0);
    tbl[10] = mk(1, 1,  0, 0, 1,  0, 0, 0, 1, 1);
    tbl[11] = mk(1, 1,  0, 0, 1,  0, 0, 0, 2, 1);
    tbl[12] = mk(1, 1,  0, 0, 1,  0, 0, 0, 3, 1);
    tbl[13] = mk(1, 1,  0, 0, 1,  0, 1, 0, 0, 1);
    tbl[14] = mk(1, 0,  0, 0, 1,  0, 0, 0, 0, 0);
    tbl[15] = mk(1, 1,  5, 0, 0,  0, 0, 0, 1, 1);
    tbl[16] = mk(1, 1,  6, 0, 0,  0, 0, 0, 2, 1);
    tbl[17] = mk(1, 1,  7, 0, 0,  0, 0, 0, 3, 1);
    tbl[18] = mk(1, 1,  8, 0, 0,  6, 1, 0, 0, 1);
    tbl[19] = mk(1, 1, 50, 0, 0,  6, 1, 1, 0, 1);
    tbl[20] = mk(1, 0,  0, 1, 0,  6, 1, 0, 0, 1);
    tbl[21] = mk(1, 1, 33, 1, 0,  6, 1, 1, 0, 1);
    tbl[22] = mk(1, 0,  0, 1, 0,  6, 1, 0, 0, 1);
    tbl[23] = mk(1, 1,  7, 0, 1,  0, 0, 0, 1, 1);
    tbl[24] = mk(1, 1,  1, 0, 1,  0, 0, 0, 2, 1);
    tbl[25] = mk(1, 1,  1, 0, 1,  0, 0, 0, 3, 1);
    tbl[26] = mk(1, 1,  3, 0, 1,  3, 1, 0, 0, 1);
    tbl[27] = mk(1, 0,  0, 0, 1,  0, 0, 0, 0, 0);
    tbl[28] = mk(1, 1,  9, 0, 1,  0, 0, 0, 1, 1);
    tbl[29] = mk(1, 1,  9, 0, 1,  0, 0, 0, 2, 1);
    tbl[30] = mk(0, 1,  9, 0, 1,  0, 0, 0, 0, 0);
    tbl[31] = mk(0, 1,  3, 0, 1,  0, 0, 0, 0, 0);
    tbl[32] = mk(1, 1,  4, 0, 1,  0, 0, 0, 1, 1);
    tbl[33] = mk(1, 1,  4, 0, 1,  0, 0, 0, 2, 1);
    tbl[34] = mk(1, 1,  4, 0, 1,  0, 0, 0, 3, 1);
    tbl[35] = mk(1, 1,  8, 0, 1,  5, 1, 0, 0, 1);
    tbl[36] = mk(0, 0,  0, 0, 0,  5, 1, 0, 0, 1);
    tbl[37] = mk(0, 1,  2, 0, 1,  0, 0, 0, 0, 0);

    // Reset state.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset", W'(0), 1'b0, 1'b0, L'(0), 1'b0, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 38; i++) begin
      step(tbl[i].en, tbl[i].eoc, int'(tbl[i].res), tbl[i].clr, tbl[i].rdy);
      check($sformatf("tbl[%0d]", i), tbl[i].e_avg, tbl[i].e_val,
            tbl[i].e_ovr, tbl[i].e_cnt, tbl[i].e_busy, 1'b0);
    end

    // Async reset with three samples in the window and an old result held.
    step(1'b1, 1'b1, 40, 1'b0, 1'b1);
    step(1'b1, 1'b1, 40, 1'b0, 1'b1);
    step(1'b1, 1'b1, 40, 1'b0, 1'b1);
    check("pre_rst_cnt3", W'(5), 1'b0, 1'b0, L'(3), 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_async", W'(0), 1'b0, 1'b0, L'(0), 1'b0, 1'b1);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 12, 1'b0, 1'b1);
    check("post_rst_1", W'(0), 1'b0, 1'b0, L'(1), 1'b1, 1'b0);
    step(1'b1, 1'b1, 12, 1'b0, 1'b1);
    step(1'b1, 1'b1, 12, 1'b0, 1'b1);
    check("post_rst_3", W'(0), 1'b0, 1'b0, L'(3), 1'b1, 1'b0);
    step(1'b1, 1'b1, 16, 1'b0, 1'b1);
    check("post_rst_avg", W'(13), 1'b1, 1'b0, L'(0), 1'b1, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b1);
    check("post_rst_ack", W'(0), 1'b0, 1'b0, L'(0), 1'b0, 1'b0);

    // Randomized traffic against the model, from a clean reset.
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rand_run(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
